// File: rtl/camera_pkg.sv
// camera_pkg -- shared definitions for the pixel readout block.
//   state_e     : readout FSM state encoding
//   ERR_*       : bit positions inside the sticky err vector
//   CONV_CNT_W  : width of the conversion counter (holds CONV_CYCLES-1 for 1..15)
package camera_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXPOSING = 3'd1,
        WAIT_ROW = 3'd2,
        CONVERT  = 3'd3,
        CAPTURE  = 3'd4
    } state_e;

    localparam int ERR_OVF  = 0;
    localparam int ERR_CONF = 1;

    localparam int CONV_CNT_W = 4;

endpackage

// File: rtl/pixel_readout_if.sv
// pixel_readout_if -- output stream of the readout block.
//   pix_data  : FIFO head sample
//   pix_valid : FIFO not empty
//   pix_addr  : {row, col} of the head sample
//   pix_ready : downstream accepts the head sample
// master = pixel_readout, slave = downstream consumer.
interface pixel_readout_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic [1:0]        pix_addr;
    logic              pix_ready;

    modport master (output pix_data, output pix_valid, output pix_addr, input pix_ready);
    modport slave  (input pix_data, input pix_valid, input pix_addr, output pix_ready);
endinterface

// File: rtl/pixel_fifo.sv
// pixel_fifo -- synchronous FIFO holding {row, col, sample} words.
//   clk, reset : clock, asynchronous active-high reset
//   flush_i    : empties the FIFO on the next edge
//   push_i     : write wdata_i (dropped when full unless a pop frees a slot)
//   pop_i      : consume the head entry when not empty
//   rdata_o    : head entry, zero while empty
//   valid_o    : FIFO not empty
//   drop_o     : a push was refused because the FIFO was full
module pixel_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         valid_o,
    output logic         drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit to separate full from empty.
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         empty, full, do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_ONE;
            if (do_pop)  rd_d = rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign valid_o = !empty;

endmodule

// File: rtl/pixel_readout.sv
// pixel_readout -- two-row, two-column pixel readout sequencer with output FIFO.
//   clk, reset       : clock, asynchronous active-high reset
//   expose           : exposure phase from the row controller
//   erase            : abort frame, flush FIFO
//   ADC_enable       : conversion window from the row controller
//   NRE_1, NRE_2     : active-low row read enables (row 0 = NRE_1)
//   adc_col0/1       : ADC results of the enabled row
//   pix              : output stream (data, valid, {row,col} addr, ready)
//   row_done         : one-cycle pulse per captured row
//   frame_done       : one-cycle pulse once both rows are captured
//   err              : sticky {row-select conflict, FIFO overflow}
module pixel_readout
    import camera_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CONV_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              expose,
    input  logic              erase,
    input  logic              ADC_enable,
    input  logic              NRE_1,
    input  logic              NRE_2,
    input  logic [DATA_W-1:0] adc_col0,
    input  logic [DATA_W-1:0] adc_col1,
    pixel_readout_if.master   pix,
    output logic              row_done,
    output logic              frame_done,
    output logic [1:0]        err
);
    localparam int FW = DATA_W + 2;
    localparam logic [CONV_CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CONV_CNT_W-1:0] CNT_LAST = CONV_CNT_W'(CONV_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CONV_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    row_q, row_d;
    logic [1:0]              seen_q, seen_d, seen_nx;
    logic                    col_q, col_d;
    logic [DATA_W-1:0]       c1_q, c1_d;
    logic                    row_done_q, row_done_d;
    logic                    frame_done_q, frame_done_d;
    logic [1:0]              err_q, err_d;

    logic                    push;
    logic [FW-1:0]           wdata;
    logic [FW-1:0]           rdata;
    logic                    drop;
    logic                    restart;

    assign restart = expose && (state_q != IDLE) && (state_q != EXPOSING);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        seen_d       = seen_q;
        seen_nx      = seen_q;
        col_d        = 1'b0;
        c1_d         = c1_q;
        row_done_d   = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        push         = 1'b0;
        wdata        = '0;

        // Second half of a capture: column 1 is written the cycle after CAPTURE.
        if (col_q) begin
            push  = 1'b1;
            wdata = {row_q, 1'b1, c1_q};
        end

        if (erase) begin
            state_d = IDLE;
            seen_d  = 2'b00;
            cnt_d   = '0;
            push    = 1'b0;
        end else if (restart) begin
            // New exposure mid-frame: start over but keep what is already queued.
            state_d = EXPOSING;
            seen_d  = 2'b00;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (expose) state_d = EXPOSING;
                end
                EXPOSING: begin
                    if (!expose) state_d = WAIT_ROW;
                end
                WAIT_ROW: begin
                    if (ADC_enable) begin
                        if (!NRE_1 && !NRE_2) begin
                            err_d[ERR_CONF] = 1'b1;
                        end else if (NRE_1 ^ NRE_2) begin
                            state_d = CONVERT;
                            row_d   = NRE_1;   // NRE_1 low selects row 0
                            cnt_d   = '0;
                        end
                    end
                end
                CONVERT: begin
                    if (!ADC_enable) begin
                        state_d = WAIT_ROW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                CAPTURE: begin
                    push       = 1'b1;
                    wdata      = {row_q, 1'b0, adc_col0};
                    col_d      = 1'b1;
                    c1_d       = adc_col1;
                    row_done_d = 1'b1;
                    seen_nx    = seen_q | (row_q ? 2'b10 : 2'b01);
                    if (&seen_nx) begin
                        frame_done_d = 1'b1;
                        seen_d       = 2'b00;
                        state_d      = IDLE;
                    end else begin
                        seen_d  = seen_nx;
                        state_d = WAIT_ROW;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (drop) err_d[ERR_OVF] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            row_q        <= 1'b0;
            seen_q       <= 2'b00;
            col_q        <= 1'b0;
            c1_q         <= '0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            seen_q       <= seen_d;
            col_q        <= col_d;
            c1_q         <= c1_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    pixel_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (erase),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pix.pix_ready),
        .rdata_o (rdata),
        .valid_o (pix.pix_valid),
        .drop_o  (drop)
    );

    assign pix.pix_data = rdata[DATA_W-1:0];
    assign pix.pix_addr = rdata[DATA_W+1:DATA_W];
    assign row_done     = row_done_q;
    assign frame_done   = frame_done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_pixel_readout.sv
// tb_pixel_readout -- directed bench for pixel_readout (default parameters:
// DATA_W=8, CONV_CYCLES=4, FIFO_DEPTH=4).
module tb_pixel_readout;
    import camera_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       expose, erase, ADC_enable, NRE_1, NRE_2;
    logic [7:0] adc_col0, adc_col1;
    logic       row_done, frame_done;
    logic [1:0] err;

    int vectors    = 0;
    int miscompares = 0;
    int rd_cnt     = 0;
    int fd_cnt     = 0;
    logic [9:0] popped [$];

    pixel_readout_if #(.DATA_W(8)) pix ();

    pixel_readout dut (
        .clk        (clk),
        .reset      (reset),
        .expose     (expose),
        .erase      (erase),
        .ADC_enable (ADC_enable),
        .NRE_1      (NRE_1),
        .NRE_2      (NRE_2),
        .adc_col0   (adc_col0),
        .adc_col1   (adc_col1),
        .pix        (pix),
        .row_done   (row_done),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // One clock: record a pop happening at this edge, then observe pulses after it.
    task automatic step();
        if (pix.pix_valid && pix.pix_ready) popped.push_back({pix.pix_addr, pix.pix_data});
        @(posedge clk);
        #1;
        if (row_done)   rd_cnt++;
        if (frame_done) fd_cnt++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic start_frame();
        expose = 1'b1;
        repeat (10) step();
        expose = 1'b0;
        step();
    endtask

    task automatic row_window(input logic row, input logic [7:0] c0, input logic [7:0] c1, input int n);
        ADC_enable = 1'b1;
        NRE_1 = row;
        NRE_2 = ~row;
        adc_col0 = c0;
        adc_col1 = c1;
        repeat (n) step();
        ADC_enable = 1'b0;
        NRE_1 = 1'b1;
        NRE_2 = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        expose = 0; erase = 0; ADC_enable = 0; NRE_1 = 1; NRE_2 = 1;
        adc_col0 = '0; adc_col1 = '0; pix.pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
        vectors++; if (pix.pix_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", pix.pix_valid); end
        vectors++; if (pix.pix_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", pix.pix_data); end
        vectors++; if (pix.pix_addr !== 2'b00) begin miscompares++; $display("FAIL reset_addr: got %b expected 00", pix.pix_addr); end
        vectors++; if ({row_done, frame_done} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b expected 00", {row_done, frame_done}); end
        vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b expected 00", err); end
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        logic [9:0] exp_q [4];
        logic [9:0] got;
        int rd0, fd0;
        exp_q = '{10'h012, 10'h134, 10'h256, 10'h378};
        apply_reset();
        pix.pix_ready = 1'b1;
        popped.delete();
        start_frame();
        vectors++; if (dut.state_q !== WAIT_ROW) begin miscompares++; $display("FAIL frame_wait_row: got %0d expected %0d", dut.state_q, WAIT_ROW); end
        rd0 = rd_cnt; fd0 = fd_cnt;
        row_window(1'b0, 8'h12, 8'h34, 6);
        row_window(1'b1, 8'h56, 8'h78, 6);
        vectors++; if (popped.size() !== 4) begin miscompares++; $display("FAIL frame_pop_count: got %0d expected 4", popped.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < popped.size()) ? popped[i] : 10'bx;
            vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL frame_pop%0d: got %h expected %h", i, got, exp_q[i]); end
        end
        vectors++; if (rd_cnt - rd0 !== 2) begin miscompares++; $display("FAIL frame_row_done: got %0d expected 2", rd_cnt - rd0); end
        vectors++; if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL frame_frame_done: got %0d expected 1", fd_cnt - fd0); end
        vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL frame_end_state: got %0d expected %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_short_window();
        int rd0;
        apply_reset();
        pix.pix_ready = 1'b0;
        start_frame();
        rd0 = rd_cnt;
        ADC_enable = 1'b1; NRE_1 = 1'b0; NRE_2 = 1'b1;
        repeat (3) step();
        ADC_enable = 1'b0; NRE_1 = 1'b1;
        repeat (3) step();
        vectors++; if (dut.state_q !== WAIT_ROW) begin miscompares++; $display("FAIL short_state: got %0d expected %0d", dut.state_q, WAIT_ROW); end
        vectors++; if (rd_cnt - rd0 !== 0) begin miscompares++; $display("FAIL short_row_done: got %0d expected 0", rd_cnt - rd0); end
        vectors++; if (pix.pix_valid !== 1'b0) begin miscompares++; $display("FAIL short_valid: got %b expected 0", pix.pix_valid); end
    endtask

    task automatic test_overflow();
        logic [9:0] exp_q [4];
        logic [9:0] got;
        int rd0, fd0;
        exp_q = '{10'h011, 10'h122, 10'h033, 10'h144};
        apply_reset();
        pix.pix_ready = 1'b0;
        popped.delete();
        start_frame();
        rd0 = rd_cnt; fd0 = fd_cnt;
        row_window(1'b0, 8'h11, 8'h22, 6);
        row_window(1'b0, 8'h33, 8'h44, 6);
        row_window(1'b0, 8'h55, 8'h66, 6);
        vectors++; if (err !== 2'b01) begin miscompares++; $display("FAIL ovf_err: got %b expected 01", err); end
        vectors++; if (rd_cnt - rd0 !== 3) begin miscompares++; $display("FAIL ovf_row_done: got %0d expected 3", rd_cnt - rd0); end
        vectors++; if (fd_cnt - fd0 !== 0) begin miscompares++; $display("FAIL ovf_frame_done: got %0d expected 0", fd_cnt - fd0); end
        pix.pix_ready = 1'b1;
        repeat (6) step();
        vectors++; if (popped.size() !== 4) begin miscompares++; $display("FAIL ovf_held: got %0d expected 4", popped.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < popped.size()) ? popped[i] : 10'bx;
            vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL ovf_pop%0d: got %h expected %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_conflict();
        int rd0;
        apply_reset();
        pix.pix_ready = 1'b0;
        start_frame();
        rd0 = rd_cnt;
        ADC_enable = 1'b1; NRE_1 = 1'b0; NRE_2 = 1'b0;
        repeat (6) step();
        ADC_enable = 1'b0; NRE_1 = 1'b1; NRE_2 = 1'b1;
        step();
        vectors++; if (err !== 2'b10) begin miscompares++; $display("FAIL conf_err: got %b expected 10", err); end
        vectors++; if (pix.pix_valid !== 1'b0) begin miscompares++; $display("FAIL conf_no_push: got %b expected 0", pix.pix_valid); end
        vectors++; if (dut.state_q !== WAIT_ROW) begin miscompares++; $display("FAIL conf_state: got %0d expected %0d", dut.state_q, WAIT_ROW); end
        row_window(1'b1, 8'h9A, 8'hBC, 6);
        vectors++; if ({pix.pix_valid, pix.pix_addr, pix.pix_data} !== 11'b1_10_10011010) begin miscompares++; $display("FAIL conf_next_row: got %b expected 11010011010", {pix.pix_valid, pix.pix_addr, pix.pix_data}); end
        vectors++; if (rd_cnt - rd0 !== 1) begin miscompares++; $display("FAIL conf_row_done: got %0d expected 1", rd_cnt - rd0); end
    endtask

    task automatic test_abort();
        int rd0;
        apply_reset();
        pix.pix_ready = 1'b0;
        start_frame();
        row_window(1'b0, 8'hA1, 8'hA2, 6);
        ADC_enable = 1'b1; NRE_1 = 1'b1; NRE_2 = 1'b0;
        repeat (2) step();
        vectors++; if (dut.state_q !== CONVERT) begin miscompares++; $display("FAIL abort_pre_state: got %0d expected %0d", dut.state_q, CONVERT); end
        vectors++; if (pix.pix_valid !== 1'b1) begin miscompares++; $display("FAIL abort_pre_valid: got %b expected 1", pix.pix_valid); end
        rd0 = rd_cnt;
        erase = 1'b1;
        step();
        vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL abort_state: got %0d expected %0d", dut.state_q, IDLE); end
        vectors++; if (pix.pix_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b expected 0", pix.pix_valid); end
        erase = 1'b0;
        repeat (5) step();
        ADC_enable = 1'b0; NRE_2 = 1'b1;
        step();
        vectors++; if (rd_cnt - rd0 !== 0) begin miscompares++; $display("FAIL abort_row_done: got %0d expected 0", rd_cnt - rd0); end
    endtask

    task automatic test_reset_mid_capture();
        apply_reset();
        pix.pix_ready = 1'b0;
        start_frame();
        ADC_enable = 1'b1; NRE_1 = 1'b0; NRE_2 = 1'b0;
        step();
        ADC_enable = 1'b0; NRE_1 = 1'b1; NRE_2 = 1'b1;
        step();
        row_window(1'b0, 8'hC1, 8'hC2, 6);
        ADC_enable = 1'b1; NRE_1 = 1'b1; NRE_2 = 1'b0;
        repeat (5) step();
        vectors++; if (dut.state_q !== CAPTURE) begin miscompares++; $display("FAIL rstcap_pre_state: got %0d expected %0d", dut.state_q, CAPTURE); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL rstcap_state: got %0d expected %0d", dut.state_q, IDLE); end
        vectors++; if ({pix.pix_valid, pix.pix_addr, pix.pix_data} !== 11'b0) begin miscompares++; $display("FAIL rstcap_stream: got %b expected 0", {pix.pix_valid, pix.pix_addr, pix.pix_data}); end
        vectors++; if ({row_done, frame_done, err} !== 4'b0000) begin miscompares++; $display("FAIL rstcap_flags: got %b expected 0000", {row_done, frame_done, err}); end
        #2 reset = 1'b0;
        ADC_enable = 1'b0; NRE_2 = 1'b1;
        step();
        vectors++; if (pix.pix_valid !== 1'b0) begin miscompares++; $display("FAIL rstcap_fifo_empty: got %b expected 0", pix.pix_valid); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_window();
        test_overflow();
        test_conflict();
        test_abort();
        test_reset_mid_capture();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_readout.md
PIXEL_READOUT -- requirements
Module: pixel_readout

Interface
REQ-001 SHALL have parameter DATA_W, default 8: ADC sample width in bits.
REQ-002 SHALL have parameter CONV_CYCLES, default 4: clk cycles from ADC_enable rise to sample capture; legal range 1..15.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, power of two.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port expose, input, 1: exposure phase active from the row controller.
REQ-007 SHALL have port erase, input, 1: pixel erase; aborts the frame.
REQ-008 SHALL have port ADC_enable, input, 1: conversion window from the row controller.
REQ-009 SHALL have ports NRE_1 and NRE_2, input, 1 each: active-low row-1 and row-2 read enables.
REQ-010 SHALL have port adc_col0, input, DATA_W: column-0 ADC result of the enabled row.
REQ-011 SHALL have port adc_col1, input, DATA_W: column-1 ADC result of the enabled row.
REQ-012 SHALL have port pix_ready, input, 1: downstream accepts pix_data.
REQ-013 SHALL have port pix_data, output, DATA_W: FIFO head sample.
REQ-014 SHALL have port pix_valid, output, 1: FIFO not empty.
REQ-015 SHALL have port pix_addr, output, 2: {row, col} of the FIFO head sample (row 0 = NRE_1).
REQ-016 SHALL have port row_done, output, 1: one-cycle pulse per completed row; drives the controller's row-timing input.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse after the row-2 capture.
REQ-018 SHALL have port err, output, 2: sticky flags, bit0 FIFO overflow, bit1 row-select conflict.

Function
REQ-019 SHALL implement states IDLE, EXPOSING, WAIT_ROW, CONVERT, CAPTURE.
REQ-020 IDLE -> EXPOSING when expose=1; EXPOSING -> WAIT_ROW when expose falls.
REQ-021 WAIT_ROW -> CONVERT on the first cycle with ADC_enable=1 and exactly one of NRE_1/NRE_2 low; the active row is latched at that cycle.
REQ-022 CONVERT SHALL count CONV_CYCLES cycles, then go to CAPTURE; if ADC_enable drops before the count ends, SHALL return to WAIT_ROW with no capture and no row_done.
REQ-023 CAPTURE SHALL last exactly one cycle, push col0 then col1 (two entries, one per cycle via a 2-entry write path or a same-cycle dual push), and assert row_done the cycle after CAPTURE.
REQ-024 After a row-1 capture, SHALL return to WAIT_ROW; after a row-2 capture, SHALL pulse frame_done together with row_done and go to IDLE.
REQ-025 Row order SHALL be free: a frame completes after both rows are captured once; a repeated row SHALL be captured again but does not count twice.
REQ-026 NRE_1=NRE_2=0 with ADC_enable=1 in WAIT_ROW SHALL set err[1], and the FSM stays in WAIT_ROW.
REQ-027 A push to a full FIFO SHALL drop that sample, set err[0], and still complete the row.
REQ-028 pix_data/pix_addr SHALL be valid whenever pix_valid=1; a pop occurs when pix_valid and pix_ready are both 1; a push and a pop in the same cycle on a full FIFO SHALL both succeed.
REQ-029 erase=1 in any state SHALL force IDLE, flush the FIFO, and clear the row-captured flags; err SHALL be held.
REQ-030 expose=1 outside IDLE/EXPOSING SHALL restart the frame: state goes to EXPOSING and row flags clear, while the FIFO is kept.
REQ-031 Row and column counters SHALL wrap modulo 2; the FIFO pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit to tell full from empty.

Reset
REQ-032 While reset=1: state=IDLE, FIFO empty, pix_valid=0, pix_data=0, pix_addr=0, row_done=0, frame_done=0, err=0, conversion counter=0.
REQ-033 On reset release, the first transition SHALL occur no earlier than the first rising clk edge.

Structure
REQ-034 SHALL put the state enum, the err bit indices and the CONV_CYCLES counter width in shared package camera_pkg.
REQ-035 The FIFO SHALL be a sub-module pixel_fifo (DATA_W+2 bits wide, FIFO_DEPTH deep, async active-high reset).
REQ-036 Total RTL SHALL be 120-400 lines.

Verification
REQ-037 Full frame: expose 10 cycles, then ADC_enable 6 cycles with NRE_1=0 (col0=0x12, col1=0x34), then the same with NRE_2=0 (0x56, 0x78), pix_ready=1 -> pix_data 0x12, 0x34, 0x56, 0x78 with addr 0, 1, 2, 3; two row_done pulses; one frame_done.
REQ-038 Short window: ADC_enable high 3 cycles with CONV_CYCLES=4 -> no capture, no row_done, state WAIT_ROW.
REQ-039 Overflow: pix_ready=0 across 3 rows (6 pushes, depth 4) -> 4 entries held, err=2'b01, row_done each row.
REQ-040 Conflict: NRE_1=NRE_2=0 with ADC_enable=1 -> err=2'b10, no push, next legal row captured normally.
REQ-041 Abort: erase=1 during CONVERT with 2 entries in the FIFO -> IDLE next cycle, pix_valid=0, no row_done.
REQ-042 Reset mid-CAPTURE: reset pulsed asynchronously between edges -> all outputs 0 immediately, FIFO empty.
